arith_issue_ctrl: RTL and testbench
===================================

Name: arith_issue_ctrl

Overview:
Upstream issue/capture stage for the 8-bit arithmetic unit (add / subtract / two's-complement, select codes 00/01/11).
- Accepts operation commands over a valid/ready handshake and drives the arithmetic unit's operand, select, carry-in and enable inputs.
- Waits a fixed settle time, then registers the result and status flags and presents them on a valid/ready output handshake.
- Supports multi-byte carry chaining from the previously captured carry.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held on the arithmetic unit before capture (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_op  in  2  00 add, 01 sub, 11 two's complement of B, 10 illegal
cmd_cin  in  1  explicit carry/borrow-in
cmd_chain  in  1  1 = use stored carry instead of cmd_cin
alu_en  out  1  arithmetic unit enable
alu_a  out  8  to arithmetic unit A
alu_b  out  8  to arithmetic unit B
alu_cin  out  1  to arithmetic unit cin
alu_s  out  2  to arithmetic unit select
alu_f  in  8  arithmetic result
alu_carry  in  1  carry/borrow out
alu_overflow  in  1  overflow
alu_zero  in  1  zero
alu_eq  in  1  A==B
alu_gt  in  1  A>B
alu_lt  in  1  A<B
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_data  out  8  captured result
res_flags  out  6  {lt,gt,eq,zero,overflow,carry}
res_err  out  1  command had illegal op

Behaviour:
- Reset values:
  - cmd_ready=1; alu_en=0; res_valid=0; res_err=0.
  - alu_a, alu_b, alu_s, alu_cin, res_data and res_flags all 0.
  - Stored carry = 0.
  - Reset is asynchronous and may assert in any state; it aborts the op in flight and discards it.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register the operands and op.
  - alu_cin = cmd_chain ? stored_carry : cmd_cin.
  - alu_en=1 from the next cycle; go to SETTLE with counter=SETTLE_CYCLES-1.
- Illegal op (10):
  - No issue: alu_en stays 0.
  - Go directly to HOLD with res_err=1, res_data=0, res_flags=0.
  - Stored carry unchanged.
- SETTLE:
  - cmd_ready=0; alu_* held stable.
  - Counter decrements each cycle.
  - At 0: capture alu_f and the flags into res_*, update stored carry from alu_carry, drop alu_en, res_valid=1, go to HOLD.
  - Latency from accept to res_valid = SETTLE_CYCLES+1 cycles.
- HOLD:
  - res_* stable until res_valid&res_ready.
  - On that handshake: res_valid=0, res_err=0, go to IDLE.
  - cmd_ready asserts in the same cycle the result is taken (no dead cycle); a new command may be accepted on the following edge.
- Flag capture is registered only; combinational changes on the alu_* inputs outside the capture cycle are ignored.
- Carry chain: stored carry is updated by every legal completed op (add carry, sub borrow, two's-complement T_C).

Optional Feature:
- Macro ARITH_ISSUE_STATS_EN.
- When defined, adds outputs stat_ops[15:0] and stat_ovf[15:0]:
  - stat_ops counts completed legal ops.
  - stat_ovf counts captures with overflow=1.
  - Both saturate at 0xFFFF and reset to 0.
- When undefined, the ports and counters are absent.

Decomposition:
- Shared package arith_pkg: op encodings (OP_ADD=00, OP_SUB=01, OP_TWC=11, OP_ILL=10), res_flags bit indices, FSM state enum.
- No sub-module: the settle counter and flag register are inline.

Test Plan:
- Add 0x7F+0x01, cin=0, chain=0 -> res_data=0x80, carry=0, lt=0, gt=1, eq=0; res_valid 2 cycles after accept (SETTLE_CYCLES=1).
- Chained add 0xFF+0x01 (carry=1) then 0x00+0x00 with chain=1 -> second result 0x01, carry=0.
- Two's complement op 11 with B=0x05 -> res_data=0xFB; B=0x00 -> res_data=0x00, zero=1, carry=1.
- Illegal op 10 -> alu_en never rises, res_err=1, res_data=0, stored carry unchanged.
- Backpressure: hold res_ready=0 for 5 cycles -> res_* stable, cmd_ready=0 throughout; release -> cmd_ready=1 in the same cycle.
- Assert rst_n=0 during SETTLE -> all outputs at reset values immediately, no res_valid after release.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic-unit issue/capture controller:
// op select encodings, result flag bit positions and the controller FSM states.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b10;
  localparam logic [1:0] OP_TWC = 2'b11;

  // Bit positions inside res_flags = {lt,gt,eq,zero,overflow,carry}
  localparam int FLG_CARRY = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_EQ    = 3;
  localparam int FLG_GT    = 4;
  localparam int FLG_LT    = 5;
  localparam int FLAGS_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic [FLAGS_W-1:0] pack_flags(input logic lt, input logic gt,
                                                    input logic eq, input logic zero,
                                                    input logic ovf, input logic carry);
    logic [FLAGS_W-1:0] f;
    f            = '0;
    f[FLG_LT]    = lt;
    f[FLG_GT]    = gt;
    f[FLG_EQ]    = eq;
    f[FLG_ZERO]  = zero;
    f[FLG_OVF]   = ovf;
    f[FLG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/arith_issue_ctrl.sv
// Issue/capture controller for the 8-bit arithmetic unit. Accepts a command,
// holds operands on the unit for SETTLE_CYCLES, then registers result and
// flags behind a valid/ready output. Stored carry supports multi-byte chains.
// Optional build macro ARITH_ISSUE_STATS_EN adds stat_ops / stat_ovf counters.
module arith_issue_ctrl
  import arith_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [1:0] cmd_op,
  input  logic       cmd_cin,
  input  logic       cmd_chain,
  output logic       alu_en,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  output logic [1:0] alu_s,
  input  logic [7:0] alu_f,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_eq,
  input  logic       alu_gt,
  input  logic       alu_lt,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [5:0] res_flags,
  output logic       res_err
`ifdef ARITH_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_ovf
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       stored_carry;
  logic       accept;
  logic       accept_ill;
  logic       capture;
  logic       res_take;

  assign accept     = cmd_valid & cmd_ready;
  assign accept_ill = accept & (cmd_op == OP_ILL);
  assign capture    = (state == ST_SETTLE) && (cnt == 4'd0);
  assign res_take   = res_valid & res_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a new command can be taken on the same edge a result leaves
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = accept_ill ? ST_HOLD : ST_SETTLE;
      ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
          if (accept) state_nxt = accept_ill ? ST_HOLD : ST_SETTLE;
          else        state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and enable outputs decoded from state
  always_comb begin
    cmd_ready = (state == ST_IDLE) || ((state == ST_HOLD) && res_ready);
    alu_en    = (state == ST_SETTLE);
    res_valid = (state == ST_HOLD);
  end

  // Operand issue register and settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_s   <= '0;
      alu_cin <= 1'b0;
      cnt     <= '0;
    end else if (accept && !accept_ill) begin
      alu_a   <= cmd_a;
      alu_b   <= cmd_b;
      alu_s   <= cmd_op;
      alu_cin <= cmd_chain ? stored_carry : cmd_cin;
      cnt     <= CNT_INIT;
    end else if ((state == ST_SETTLE) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Result/flag capture, illegal-op reporting and carry chain storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data     <= '0;
      res_flags    <= '0;
      res_err      <= 1'b0;
      stored_carry <= 1'b0;
    end else if (capture) begin
      res_data     <= alu_f;
      res_flags    <= pack_flags(alu_lt, alu_gt, alu_eq, alu_zero, alu_overflow, alu_carry);
      res_err      <= 1'b0;
      stored_carry <= alu_carry;
    end else if (accept_ill) begin
      res_data  <= '0;
      res_flags <= '0;
      res_err   <= 1'b1;
    end else if (res_take) begin
      res_err <= 1'b0;
    end
  end

`ifdef ARITH_ISSUE_STATS_EN
  // Saturating counts of completed ops and overflowing captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (capture) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (alu_overflow && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arith_issue_ctrl.sv
// Scoreboard bench for arith_issue_ctrl with a behavioural arithmetic unit.
module tb_arith_issue_ctrl;
  import arith_pkg::*;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic       cmd_cin = 1'b0, cmd_chain = 1'b0;
  logic       alu_en, alu_cin;
  logic [7:0] alu_a, alu_b, alu_f;
  logic [1:0] alu_s;
  logic       alu_carry, alu_overflow, alu_zero, alu_eq, alu_gt, alu_lt;
  logic       res_valid, res_ready = 1'b0;
  logic [7:0] res_data;
  logic [5:0] res_flags;
  logic       res_err;
`ifdef ARITH_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_ovf;
`endif

  arith_issue_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
    .alu_f(alu_f), .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_err(res_err)
`ifdef ARITH_ISSUE_STATS_EN
    , .stat_ops(stat_ops), .stat_ovf(stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural arithmetic unit: returns {f[7:0], lt, gt, eq, zero, ovf, carry}
  function automatic logic [13:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s, input logic cin);
    int   r;
    logic [7:0] f;
    logic c, v;
    if (s == 2'b00) begin
      r = int'(a) + int'(b) + int'(cin);
      f = r[7:0]; c = (r > 255);
      v = (a[7] == b[7]) && (f[7] != a[7]);
    end else if (s == 2'b01) begin
      r = int'(a) - int'(b) - int'(cin);
      f = r[7:0]; c = (r < 0);
      v = (a[7] != b[7]) && (f[7] != a[7]);
    end else begin
      r = 256 - int'(b);
      f = r[7:0]; c = (b == 8'h00);
      v = (b == 8'h80);
    end
    return {f, (a < b), (a > b), (a == b), (f == 8'h00), v, c};
  endfunction

  // Outside the enabled window the unit outputs noise, so any stray capture is visible
  logic [13:0] noise = '0;
  logic [13:0] alu_out;
  always @(posedge clk) noise <= 14'($urandom);
  assign alu_out = alu_en ? alu_eval(alu_a, alu_b, alu_s, alu_cin) : noise;
  assign alu_f        = alu_out[13:6];
  assign alu_lt       = alu_out[5];
  assign alu_gt       = alu_out[4];
  assign alu_eq       = alu_out[3];
  assign alu_zero     = alu_out[2];
  assign alu_overflow = alu_out[1];
  assign alu_carry    = alu_out[0];

  typedef struct {
    logic       err;
    logic [7:0] data;
    logic [5:0] flags;
    logic [7:0] a, b;
    logic [1:0] op;
    logic       cin;
    longint     acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  logic model_carry = 1'b0;
  int   stall = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer: random ready, with forced stalls on request
  always @(negedge clk) begin
    if (stall > 0) begin
      res_ready = 1'b0;
      stall = stall - 1;
    end else begin
      res_ready = ($urandom_range(3) != 0);
    end
  end

  // Monitor / scoreboard
  logic       prev_valid = 1'b0, prev_take = 1'b0;
  logic [7:0] prev_data;
  logic [5:0] prev_flags;
  logic       prev_err;
  int         en_cnt = 0;
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      prev_valid = 1'b0; prev_take = 1'b0; en_cnt = 0;
    end else begin
      if (alu_en) begin
        en_cnt++;
        if (exp_q.size() > 0) begin
          chk("alu_a", 16'(alu_a), 16'(exp_q[0].a));
          chk("alu_b", 16'(alu_b), 16'(exp_q[0].b));
          chk("alu_s", 16'(alu_s), 16'(exp_q[0].op));
          chk("alu_cin", 16'(alu_cin), 16'(exp_q[0].cin));
        end
      end
      if (res_valid && exp_q.size() == 0) begin
        chk("unexpected_res_valid", 16'(res_valid), 16'd0);
      end else if (res_valid) begin
        if (!prev_valid || prev_take) begin
          chk("latency", 16'(cyc - exp_q[0].acc_cyc), exp_q[0].err ? 16'd1 : 16'(SETTLE + 1));
          chk("alu_en_cycles", 16'(en_cnt), exp_q[0].err ? 16'd0 : 16'(SETTLE));
          en_cnt = 0;
        end else begin
          chk("hold_data", 16'(res_data), 16'(prev_data));
          chk("hold_flags", 16'(res_flags), 16'(prev_flags));
          chk("hold_err", 16'(res_err), 16'(prev_err));
        end
        chk("cmd_ready_in_hold", 16'(cmd_ready), 16'(res_ready));
        if (res_ready) begin
          chk("res_err", 16'(res_err), 16'(exp_q[0].err));
          chk("res_data", 16'(res_data), 16'(exp_q[0].data));
          chk("res_flags", 16'(res_flags), 16'(exp_q[0].flags));
          void'(exp_q.pop_front());
        end
      end
      prev_valid = res_valid;
      prev_take  = res_valid & res_ready;
      prev_data  = res_data;
      prev_flags = res_flags;
      prev_err   = res_err;
    end
  end

  // Driver: present a command, push expectation when it is accepted
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic cin, input logic chain);
    int   t;
    exp_t e;
    logic [13:0] r;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin; cmd_chain = chain;
    while (1) begin
      #2;
      if (cmd_ready) break;
      t++;
      if (t > 200) begin
        chk("cmd_ready_timeout", 16'd0, 16'd1);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.a = a; e.b = b; e.op = op; e.acc_cyc = cyc;
    e.cin = chain ? model_carry : cin;
    if (op == 2'b10) begin
      e.err = 1'b1; e.data = 8'h00; e.flags = 6'h00;
    end else begin
      r = alu_eval(a, b, op, e.cin);
      e.err = 1'b0; e.data = r[13:6]; e.flags = r[5:0];
      model_carry = r[0];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 16'(exp_q.size()), 16'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 16'(cmd_ready), 16'd1);
    chk({tag, "_alu_en"}, 16'(alu_en), 16'd0);
    chk({tag, "_res_valid"}, 16'(res_valid), 16'd0);
    chk({tag, "_res_err"}, 16'(res_err), 16'd0);
    chk({tag, "_alu_ops"}, {alu_a, alu_b}, 16'd0);
    chk({tag, "_alu_s_cin"}, 16'({alu_s, alu_cin}), 16'd0);
    chk({tag, "_res_data_flags"}, 16'({res_data, res_flags}), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0);
    send(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0);
    send(8'h00, 8'h00, OP_ADD, 1'b0, 1'b1);
    send(8'h33, 8'h05, OP_TWC, 1'b0, 1'b0);
    send(8'h00, 8'h00, OP_TWC, 1'b0, 1'b0);
    send(8'h12, 8'h34, OP_ILL, 1'b0, 1'b0);
    send(8'h00, 8'h00, OP_ADD, 1'b0, 1'b1);
    send(8'h10, 8'h20, OP_SUB, 1'b1, 1'b0);
    drain();

    // Backpressure: consumer stalls well past the capture
    stall = 8;
    send(8'h80, 8'h80, OP_ADD, 1'b0, 1'b0);
    drain();

    // Randomised traffic including illegal ops and chaining
    for (int i = 0; i < 200; i++) begin
      send(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    // Reset during SETTLE: in-flight op discarded, stored carry cleared
    send(8'hFF, 8'hFF, OP_ADD, 1'b0, 1'b0);
    drain();
    send(8'h01, 8'h02, OP_ADD, 1'b0, 1'b0);
    chk("in_settle_before_reset", 16'(alu_en), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    exp_q.delete();
    model_carry = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (res_valid) seen++;
    end
    chk("no_res_after_reset", 16'(seen), 16'd0);
    send(8'h00, 8'h00, OP_ADD, 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
